// File: rtl/bcd_convert_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bcd_convert_ctrl_pkg
//   Shared definitions for the binary-to-BCD conversion sequencer.
//   - state_t     : FSM encoding (IDLE / SHIFT / DONE)
//   - DIGIT_W     : bits per BCD digit
//   - ADD3_THRESH : digit value at or above which the +3 correction applies
// -----------------------------------------------------------------------------
package bcd_convert_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int         DIGIT_W     = 4;
   localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
//   Combinational double-dabble digit corrector: a digit of 5 or more gets +3
//   so that the following left shift carries correctly into the next digit.
//   Ports:
//     digit_i  in   DIGIT_W  scratch digit before correction
//     digit_o  out  DIGIT_W  corrected digit (4-bit wrap, no carry out)
// -----------------------------------------------------------------------------
module bcd_add3
   import bcd_convert_ctrl_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [DIGIT_W-1:0] digit_o
);

   always_comb begin
      digit_o = digit_i;
      if (digit_i >= ADD3_THRESH) begin
         digit_o = digit_i + 4'd3;
      end
   end

endmodule

// File: rtl/bcd_convert_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_convert_ctrl
//   Sequencer for the binary-to-BCD path. Captures a binary word on start,
//   runs WIDTH shift-and-add-3 iterations, then publishes the packed BCD
//   result together with a one-cycle done pulse. The published result only
//   changes on completion, so downstream display logic never sees a partial
//   conversion.
//   Parameters:
//     WIDTH   binary input width (4..16)
//     DIGITS  BCD output digits; 10^DIGITS must exceed 2^WIDTH-1
//   Ports:
//     clk    in   1           rising-edge clock
//     rst    in   1           synchronous active-high reset
//     start  in   1           conversion request, honoured only in IDLE
//     bin    in   WIDTH       unsigned value, captured with an accepted start
//     busy   out  1           high while iterations run
//     done   out  1           one-cycle completion pulse
//     bcd    out  4*DIGITS    packed result, units digit in [3:0]
// -----------------------------------------------------------------------------
module bcd_convert_ctrl
   import bcd_convert_ctrl_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [WIDTH-1:0]           bin,
   output logic                       busy,
   output logic                       done,
   output logic [DIGIT_W*DIGITS-1:0]  bcd
);

   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic [WIDTH-1:0]   bin_sr_q;
   logic [WIDTH-1:0]   bin_sr_d;
   logic [BCD_W-1:0]   scr_q;
   logic [BCD_W-1:0]   scr_adj;
   logic [BCD_W-1:0]   scr_d;
   logic [BCD_W-1:0]   bcd_q;
   logic               busy_q;
   logic               done_q;

   // Per-digit +3 correction applied to the scratch register before each shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .digit_i (scr_q  [g*DIGIT_W +: DIGIT_W]),
         .digit_o (scr_adj[g*DIGIT_W +: DIGIT_W])
      );
   end

   // One iteration: shift {corrected scratch, binary} left by one bit.
   always_comb begin
      scr_d    = {scr_adj[BCD_W-2:0], bin_sr_q[WIDTH-1]};
      bin_sr_d = {bin_sr_q[WIDTH-2:0], 1'b0};
      cnt_d    = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         bin_sr_q <= '0;
         scr_q    <= '0;
         bcd_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  bin_sr_q <= bin;
                  scr_q    <= '0;
                  cnt_q    <= CNT_W'(WIDTH);
                  busy_q   <= 1'b1;
                  state_q  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               bin_sr_q <= bin_sr_d;
               scr_q    <= scr_d;
               cnt_q    <= cnt_d;
               // Last iteration: publish the post-shift scratch directly.
               if (cnt_q == CNT_W'(1)) begin
                  bcd_q   <= scr_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;

endmodule

// File: doc/bcd_convert_ctrl.md
# bcd_convert_ctrl

Sequencer for the binary-to-BCD path: captures a binary word on a start request, runs the shift-and-add-3 (double-dabble) iterations under an internal iteration counter, and presents the packed BCD result with a one-cycle done pulse. Sits between the counter/value sources and the digit display logic, so display drivers never see a half-converted value.

## Interface
- WIDTH, 8, binary input width; legal range 4–16.
- DIGITS, 3, BCD output digits; must satisfy 10^DIGITS > 2^WIDTH − 1. The default pair is the checked configuration.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  WIDTH  unsigned binary value; sampled only in the cycle start is accepted.
- busy  output  1  high while iterations are running (SHIFT state).
- done  output  1  one-cycle pulse; bcd holds the new result in that cycle.
- bcd  output  4*DIGITS  packed result; digit 0 (units) in bits [3:0]; held until the next completion.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Load the binary shift register with bin.
  - Clear the scratch BCD register.
  - Load the iteration counter with WIDTH.
  - Go to SHIFT.
- IDLE, start=0: stay.
- SHIFT, each cycle:
  - Every scratch digit ≥ 5 gets +3, unsigned 4-bit, no carry out of the digit.
  - Then shift {scratch, binary} left by 1: binary MSB enters scratch bit 0; binary LSB fills with 0.
  - Decrement the counter.
- SHIFT, counter reaches 0 after the shift: load bcd from the post-shift scratch value and go to DONE.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
- start is ignored in SHIFT and DONE: not queued, no effect on the conversion in progress.
- bin changes after acceptance have no effect.
- Inputs 0 and 2^WIDTH − 1 need no special case. For 8-bit 255, bcd is 0x255 and no digit exceeds 9.
- Counter width is ceil(log2(WIDTH+1)). It never wraps: SHIFT exits on reaching 0.

## Timing
- Reset values: state IDLE, busy 0, done 0, bcd 0, counter 0, scratch and binary shift registers 0.
- start accepted at edge T:
  - busy=1 in cycles T+1 … T+WIDTH.
  - done=1 and new bcd in cycle T+WIDTH+1.
  - Next start accepted at edge T+WIDTH+2 at the earliest.
- With WIDTH=8: 9-cycle latency from accepted start to done; throughput one conversion per 10 cycles.
- bcd updates only on the SHIFT→DONE transition. It is stable at all other times, including during the next conversion.
- rst mid-conversion, in SHIFT or DONE:
  - Aborts the conversion; no done pulse.
  - bcd clears to 0 in the cycle after the reset edge.
  - FSM is in IDLE and accepts start in the first cycle after rst deasserts.
- rst and start high together: rst wins; start is not accepted.
- busy and done are never high together.

## Structure
- Shared package holds:
  - the state encoding constants IDLE/SHIFT/DONE;
  - the digit width constant (4);
  - the add-3 threshold constant (5).
- One sub-module, bcd_add3: combinational 4-bit digit corrector (≥5 → +3). Instantiated DIGITS times via generate.
- Counter, FSM and shift registers stay in bcd_convert_ctrl.

## Test plan
- Reset release, then bin=8'd0 with start at edge T → busy for T+1..T+8; done at T+9 with bcd=12'h000.
- bin=8'd255 → bcd=12'h255 with done at T+9. Repeat with bin=8'd99 → 12'h099 and bin=8'd100 → 12'h100.
- start held high continuously with bin changing every cycle → bin is captured only at accepted edges, one done per 10 cycles, each result matching its captured value.
- start pulsed during SHIFT with a different bin → ignored; result matches the originally captured bin; no extra done.
- rst asserted at T+4 during a conversion of 8'd200 → no done pulse; bcd=0 and busy=0 after the reset edge; a new start of 8'd42 then completes with 12'h042.
- Previous result 12'h255, then a new conversion of 8'd7 → bcd stays 12'h255 during busy and changes to 12'h007 exactly in the done cycle.
